// File: rtl/goto_protocol_checker.sv
// goto_protocol_checker
//   Multi-channel checker for the req / busy[->BUSY_CNT] / gnt protocol. Each channel is
//   armed by req. It then counts busy samples, which may be separated by gaps. The cycle
//   after the BUSY_CNT-th busy must carry gnt. Results are reported as registered pass/fail
//   pulses with an error code. Global saturating counters keep the totals.
//
// Optional feature: define GOTO_CHK_TIMEOUT_EN to fail a channel with code 3 once it has
//   spent TIMEOUT consecutive COUNT cycles without a busy sample.
//
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   req, busy, gnt    per-channel protocol inputs
//   active            channel tracker is armed (not idle)
//   pass, fail        one-cycle result pulses, mutually exclusive per channel
//   err_code          2 bits per channel: 1 early gnt, 2 missing gnt, 3 timeout; 0 unless fail
//   pass_cnt, fail_cnt saturating totals of pass / fail pulses
module goto_protocol_checker #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned BUSY_CNT = 3,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   req,
  input  logic [NUM_CH-1:0]   busy,
  input  logic [NUM_CH-1:0]   gnt,
  output logic [NUM_CH-1:0]   active,
  output logic [NUM_CH-1:0]   pass,
  output logic [NUM_CH-1:0]   fail,
  output logic [2*NUM_CH-1:0] err_code,
  output logic [STAT_W-1:0]   pass_cnt,
  output logic [STAT_W-1:0]   fail_cnt
);

  localparam int unsigned BW = $clog2(BUSY_CNT + 1);
  localparam logic [BW-1:0] BusyLast = BW'(BUSY_CNT);

  localparam logic [1:0] ErrEarlyGnt   = 2'd1;
  localparam logic [1:0] ErrMissingGnt = 2'd2;
`ifdef GOTO_CHK_TIMEOUT_EN
  localparam logic [1:0] ErrTimeout    = 2'd3;
  // Counter holds 0..TIMEOUT-1; the increment that would reach TIMEOUT fires the failure.
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {StIdle, StCount, StGntWait} state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [BW-1:0] bcnt_inc;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic [1:0]    code_q, code_d;
`ifdef GOTO_CHK_TIMEOUT_EN
    logic [TW-1:0] tcnt_q, tcnt_d;
`endif

    assign bcnt_inc = bcnt_q + 1'b1;

    always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      code_d  = 2'd0;
`ifdef GOTO_CHK_TIMEOUT_EN
      tcnt_d  = tcnt_q;
`endif
      unique case (state_q)
        StIdle: begin
          if (req[i]) begin
            state_d = StCount;
            bcnt_d  = '0;
`ifdef GOTO_CHK_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
        StCount: begin
          // Early grant outranks both busy and timeout at the same edge.
          if (gnt[i]) begin
            fail_d  = 1'b1;
            code_d  = ErrEarlyGnt;
            state_d = StIdle;
          end else if (busy[i]) begin
            bcnt_d = bcnt_inc;
`ifdef GOTO_CHK_TIMEOUT_EN
            tcnt_d = '0;
`endif
            if (bcnt_inc == BusyLast) begin
              state_d = StGntWait;
            end
          end
`ifdef GOTO_CHK_TIMEOUT_EN
          else if (tcnt_q == TmoLast) begin
            fail_d  = 1'b1;
            code_d  = ErrTimeout;
            state_d = StIdle;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        StGntWait: begin
          state_d = StIdle;
          if (gnt[i]) begin
            pass_d = 1'b1;
          end else begin
            fail_d = 1'b1;
            code_d = ErrMissingGnt;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StIdle;
        bcnt_q  <= '0;
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
        code_q  <= 2'd0;
`ifdef GOTO_CHK_TIMEOUT_EN
        tcnt_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        bcnt_q  <= bcnt_d;
        pass_q  <= pass_d;
        fail_q  <= fail_d;
        code_q  <= code_d;
`ifdef GOTO_CHK_TIMEOUT_EN
        tcnt_q  <= tcnt_d;
`endif
      end
    end

    assign active[i]         = (state_q != StIdle);
    assign pass[i]           = pass_q;
    assign fail[i]           = fail_q;
    assign err_code[2*i +: 2] = code_q;
  end

  // Global totals: add this cycle's registered pulses, clamp at all-ones.
  localparam int unsigned PW = $clog2(NUM_CH + 1);
  localparam int unsigned SW = ((STAT_W > PW) ? STAT_W : PW) + 1;
  localparam logic [STAT_W-1:0] StatMax = '1;

  logic [PW-1:0]     pass_pop, fail_pop;
  logic [SW-1:0]     pass_sum, fail_sum;
  logic [STAT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [STAT_W-1:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    pass_pop = '0;
    fail_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_pop = pass_pop + PW'(pass[i]);
      fail_pop = fail_pop + PW'(fail[i]);
    end
    pass_sum   = SW'(pass_cnt_q) + SW'(pass_pop);
    fail_sum   = SW'(fail_cnt_q) + SW'(fail_pop);
    pass_cnt_d = (pass_sum > SW'(StatMax)) ? StatMax : pass_sum[STAT_W-1:0];
    fail_cnt_d = (fail_sum > SW'(StatMax)) ? StatMax : fail_sum[STAT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_goto_protocol_checker.sv
module tb_goto_protocol_checker;

  localparam int unsigned NCH  = 4;
  localparam int unsigned BC   = 3;
  localparam int unsigned TMO  = 8;
  localparam int unsigned SW   = 3;
  localparam int          MAXC = (1 << SW) - 1;
`ifdef GOTO_CHK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req, busy, gnt;
  logic [NCH-1:0]   active, pass, fail;
  logic [2*NCH-1:0] err_code;
  logic [SW-1:0]    pass_cnt, fail_cnt;

  goto_protocol_checker #(
    .NUM_CH  (NCH),
    .BUSY_CNT(BC),
    .TIMEOUT (TMO),
    .STAT_W  (SW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .busy    (busy),
    .gnt     (gnt),
    .active  (active),
    .pass    (pass),
    .fail    (fail),
    .err_code(err_code),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: per channel, whether armed, busies seen, quiet cycles since the
  // last busy. Results are registered, so decisions made at an edge are visible afterwards.
  bit               armed [NCH];
  int               nb    [NCH];
  int               quiet [NCH];
  logic [NCH-1:0]   m_pass = '0;
  logic [NCH-1:0]   m_fail = '0;
  logic [2*NCH-1:0] m_err  = '0;
  int               tot_p  = 0;
  int               tot_f  = 0;

  function automatic int sat(input int t);
    return (t > MAXC) ? MAXC : t;
  endfunction

  function automatic logic [NCH-1:0] m_active();
    logic [NCH-1:0] a;
    for (int c = 0; c < NCH; c++) a[c] = armed[c];
    return a;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int c = 0; c < NCH; c++) begin
          armed[c] = 1'b0; nb[c] = 0; quiet[c] = 0;
        end
        m_pass = '0; m_fail = '0; m_err = '0; tot_p = 0; tot_f = 0;
      end else begin
        tot_p += $countones(m_pass);
        tot_f += $countones(m_fail);
        m_pass = '0; m_fail = '0; m_err = '0;
        for (int c = 0; c < NCH; c++) begin
          if (!armed[c]) begin
            if (req[c]) begin armed[c] = 1'b1; nb[c] = 0; quiet[c] = 0; end
          end else if (nb[c] == BC) begin
            armed[c] = 1'b0;
            if (gnt[c]) m_pass[c] = 1'b1;
            else begin m_fail[c] = 1'b1; m_err[2*c +: 2] = 2'd2; end
          end else if (gnt[c]) begin
            armed[c] = 1'b0; m_fail[c] = 1'b1; m_err[2*c +: 2] = 2'd1;
          end else if (busy[c]) begin
            nb[c]++; quiet[c] = 0;
          end else begin
            quiet[c]++;
            if (TMO_EN && quiet[c] == TMO) begin
              armed[c] = 1'b0; m_fail[c] = 1'b1; m_err[2*c +: 2] = 2'd3;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("active", 32'(active), 32'(m_active()));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("err_code", 32'(err_code), 32'(m_err));
      chk("pass_cnt", 32'(pass_cnt), sat(tot_p));
      chk("fail_cnt", 32'(fail_cnt), sat(tot_f));
    end
  end

  task automatic cyc(input logic [NCH-1:0] r, input logic [NCH-1:0] b, input logic [NCH-1:0] g);
    @(negedge clk);
    req = r; busy = b; gnt = g;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1; req = '0; busy = '0; gnt = '0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // req at edge 0, busy at edges 2/4/6, gnt vector g7 at edge 7.
  task automatic seq(input logic [NCH-1:0] r, input logic [NCH-1:0] g7);
    cyc(r, '0, '0); cyc('0, '0, '0); cyc('0, r, '0); cyc('0, '0, '0);
    cyc('0, r, '0); cyc('0, '0, '0); cyc('0, r, '0); cyc('0, '0, g7);
  endtask

  initial begin
    rst = 1'b1; req = '0; busy = '0; gnt = '0;
    #1;
    chk("reset active", 32'(active), 0);
    chk("reset err", 32'(err_code), 0);
    chk("reset cnt", 32'({pass_cnt, fail_cnt}), 0);
    @(negedge clk); #2 rst = 1'b0;

    // Single passing transaction on channel 0.
    seq(4'b0001, 4'b0001);
    cyc('0, '0, '0);
    chk("t1 pass", 32'(pass), 32'h1);
    chk("t1 fail", 32'(fail), 32'h0);
    cyc('0, '0, '0);
    chk("t1 pass_cnt", 32'(pass_cnt), 1);
    chk("t1 fail_cnt", 32'(fail_cnt), 0);

    // Grant one cycle late: missing grant, late gnt ignored in idle.
    do_reset();
    seq(4'b0001, 4'b0000);
    cyc('0, '0, 4'b0001);
    chk("t2 fail", 32'(fail), 32'h1);
    chk("t2 err", 32'(err_code), 32'h02);
    cyc('0, '0, '0);
    chk("t2 fail_cnt", 32'(fail_cnt), 1);
    chk("t2 active", 32'(active), 0);

    // Early grant after one busy; busy+gnt afterwards without req has no effect.
    do_reset();
    cyc(4'b0001, '0, '0); cyc('0, '0, '0); cyc('0, 4'b0001, '0); cyc('0, '0, 4'b0001);
    cyc('0, 4'b0001, 4'b0001);
    chk("t3 fail", 32'(fail), 32'h1);
    chk("t3 err", 32'(err_code), 32'h01);
    cyc('0, '0, '0);
    chk("t3 active", 32'(active), 0);
    chk("t3 fail after", 32'(fail), 0);

    // One busy then silence.
    do_reset();
    cyc(4'b0001, '0, '0); cyc('0, 4'b0001, '0);
    idle(8);
    cyc('0, '0, '0);
    chk("t4 fail", 32'(fail), TMO_EN ? 32'h1 : 32'h0);
    chk("t4 err", 32'(err_code), TMO_EN ? 32'h3 : 32'h0);
    idle(30);
    chk("t4 active", 32'(active), TMO_EN ? 32'h0 : 32'h1);

    // All channels at once, channel 2 misses its grant.
    do_reset();
    seq(4'b1111, 4'b1011);
    cyc('0, '0, '0);
    chk("t5 pass", 32'(pass), 32'hb);
    chk("t5 fail", 32'(fail), 32'h4);
    chk("t5 err", 32'(err_code), 32'h20);
    cyc('0, '0, '0);
    chk("t5 pass_cnt", 32'(pass_cnt), 3);
    chk("t5 fail_cnt", 32'(fail_cnt), 1);

    // Eight more passes: 11 total saturates a 3-bit counter at 7.
    seq(4'b1111, 4'b1111);
    seq(4'b1111, 4'b1111);
    idle(2);
    chk("t6 pass_cnt sat", 32'(pass_cnt), 7);
    chk("t6 fail_cnt", 32'(fail_cnt), 1);

    // req at the pass edge is ignored.
    cyc(4'b0001, '0, '0); cyc('0, '0, '0); cyc('0, 4'b0001, '0); cyc('0, '0, '0);
    cyc('0, 4'b0001, '0); cyc('0, '0, '0); cyc('0, 4'b0001, '0); cyc(4'b0001, '0, 4'b0001);
    cyc('0, '0, '0);
    chk("t7 pass", 32'(pass), 32'h1);
    chk("t7 active", 32'(active), 0);

    // Asynchronous reset mid-COUNT.
    cyc(4'b1111, '0, '0); cyc('0, 4'b1111, '0); cyc('0, '0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t8 active", 32'(active), 0);
    chk("t8 cnts", 32'({pass_cnt, fail_cnt}), 0);
    chk("t8 fail", 32'(fail), 0);
    @(negedge clk); #2 rst = 1'b0;
    idle(3);
    chk("t8 no fail", 32'(fail), 0);

    // Mixed traffic checked by the model only.
    for (int n = 0; n < 400; n++) begin
      logic [NCH-1:0] r, b, g;
      for (int c = 0; c < NCH; c++) begin
        r[c] = ($urandom_range(3) == 0);
        b[c] = ($urandom_range(1) == 0);
        g[c] = ($urandom_range(5) == 0);
      end
      cyc(r, b, g);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/goto_protocol_checker.md
# goto_protocol_checker

Synthesisable, multi-channel checker for the request/busy/grant goto-repetition protocol. For each channel, a sampled `req` arms a tracker. The tracker counts `busy` samples, which may be non-consecutive and separated by any gap. After the BUSY_CNT-th busy, the tracker requires `gnt` in the next cycle. Each channel reports pass or fail with an error code, and global saturating counters record totals. The block sits beside the arbiter in silicon and FPGA builds, where the simulation-only assertions are not available.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- BUSY_CNT, 3, busy occurrences required before grant (≥1)
- TIMEOUT, 64, max cycles allowed in COUNT without a busy sample (≥2)
- STAT_W, 16, width of the global pass/fail counters

Ports:
- clk  in  1  sampling clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_CH  per-channel request
- busy  in  NUM_CH  per-channel busy indication
- gnt  in  NUM_CH  per-channel grant
- active  out  NUM_CH  channel tracker is not IDLE
- pass  out  NUM_CH  one-cycle pulse: transaction met protocol
- fail  out  NUM_CH  one-cycle pulse: protocol violation
- err_code  out  2*NUM_CH  code for channel i in bits [2i+1:2i]; valid while fail[i]=1; 0 otherwise
- pass_cnt  out  STAT_W  saturating total of pass pulses
- fail_cnt  out  STAT_W  saturating total of fail pulses

## Operation
Each channel has an independent FSM with states IDLE, COUNT and GNT_WAIT. Each channel also has a busy counter of $clog2(BUSY_CNT+1) bits and a timeout counter.

- IDLE
  - `req`=1 → COUNT. Busy counter and timeout counter clear to 0.
  - `busy` and `gnt` are ignored.
- COUNT
  - `gnt`=1 → fail with code 1 (EARLY_GNT), then IDLE. This takes priority over `busy` in the same cycle.
  - Otherwise, `busy`=1 increments the busy counter and clears the timeout counter.
  - When the increment reaches BUSY_CNT → GNT_WAIT.
  - `req` is ignored; there is no re-arm.
- GNT_WAIT (exactly one cycle)
  - `gnt`=1 → pass, then IDLE.
  - `gnt`=0 → fail with code 2 (MISSING_GNT), then IDLE.
  - `req` and `busy` are ignored in this state.
- Error code 3 (TIMEOUT): see Configuration. Code 0 is never reported with fail.
- Pass and fail on a channel are mutually exclusive.
- `pass_cnt` and `fail_cnt` add the popcount of the pass and fail vectors each cycle, so multiple channels may report simultaneously. Both counters saturate at 2^STAT_W−1 and never wrap.
- Channels never interact, apart from the shared counters.

## Timing
- Reset values: every FSM in IDLE; `active`=0, `pass`=0, `fail`=0, `err_code`=0, `pass_cnt`=0, `fail_cnt`=0.
- Asserting `rst` mid-transaction aborts every tracker immediately and produces no fail pulse.
- All outputs are registered. A decision sampled at edge k drives pass/fail/err_code during cycle k→k+1. The counters reflect that decision one edge later.
- `active` rises at the edge that samples `req`. It falls at the edge that produces pass/fail.
- Minimum transaction length is 1+BUSY_CNT+1 cycles, with `req` at edge 0, busy at edges 1..BUSY_CNT, and `gnt` at edge BUSY_CNT+1.
- A `req` sampled at the same edge that produces pass/fail is ignored, because the FSM was not in IDLE. The next arm needs `req` at a later edge.
- BUSY_CNT=1: the first busy in COUNT moves the FSM to GNT_WAIT.

## Configuration
- Macro: `GOTO_CHK_TIMEOUT_EN`.
- Defined:
  - The timeout counter increments every COUNT cycle without busy.
  - When it reaches TIMEOUT → fail with code 3, then IDLE. EARLY_GNT has priority at the same edge.
- Undefined:
  - The timeout logic is removed.
  - COUNT waits indefinitely.
  - Code 3 is never produced.

## Test plan
- NUM_CH=1, BUSY_CNT=3. Stimulus: req at edge 0; busy pulses at edges 2, 4, 6; gnt at edge 7 → pass=1 for one cycle after edge 7; pass_cnt=1; fail_cnt=0.
- Same stimulus, but gnt at edge 8 instead of 7 → fail with err_code=2 after edge 7; fail_cnt=1. The gnt at edge 8 is ignored in IDLE.
- req at edge 0; busy at edge 2; gnt at edge 3 → fail with err_code=1 after edge 3. busy and gnt both high at edge 4 with no new req → no effect.
- With `GOTO_CHK_TIMEOUT_EN` and TIMEOUT=8: req at edge 0; one busy at edge 1; no further busy → fail with err_code=3 after edge 9. Without the macro, active stays 1 indefinitely.
- NUM_CH=4, all channels run the passing sequence simultaneously, with channel 2 missing gnt → pass=4'b1011 and fail=4'b0100 in the same cycle; pass_cnt=3; fail_cnt=1.
- STAT_W=2, run 5 passing transactions → pass_cnt stops at 3. Asserting rst during COUNT → active=0 and all counters 0, with no fail pulse.
